rip_div_ctrl: RTL and testbench
===============================

# rip_div_ctrl

Sequencer for the RV32M divide/remainder instructions (DIV, DIVU, REM, REMU) in the execute stage. It accepts one operation from the decoded instruction stream, runs a 32-iteration restoring division on an internal shift-subtract datapath, and handles the special cases (divide-by-zero, signed overflow) in a single cycle. While an operation is in progress it holds the pipeline through `ex_stall`. It presents a registered result with a one-cycle `done` pulse.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; high while a DIV/DIVU/REM/REMU occupies EX and its operands are valid.
- `op`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with `start`.
- `dividend`  in  32  rs1 value; sampled with `start`.
- `divisor`  in  32  rs2 value; sampled with `start`.
- `flush`  in  1  abort (trap/redirect); has priority over everything except reset.
- `ex_stall`  out  1  combinational; freeze IF/DE/EX registers.
- `busy`  out  1  registered; high in CALC or FIX.
- `done`  out  1  registered; one-cycle pulse, `result` valid.
- `result`  out  32  registered quotient or remainder; holds until next completion.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset: IDLE, `result`=0, `done`=0, `busy`=0, iteration counter=0, internal regs 0.
- Accept: `start`=1 in IDLE or DONE, with `flush`=0. Otherwise `start` is ignored.
- Latch signed flag (op[0]=0) and remainder flag (op[1]). Latch operand magnitudes: absolute values when signed, raw values otherwise. Latch sign flags: q_neg = signed & (a[31]^b[31]) & (b!=0); r_neg = signed & a[31].
- Fast path, decided at acceptance. Next state DONE, `result` loaded on the same edge:
  - divisor==0: quotient 0xFFFF_FFFF; remainder = dividend (unmodified).
  - signed, dividend==0x8000_0000, divisor==0xFFFF_FFFF: quotient 0x8000_0000; remainder 0.
- Normal path: next state CALC, counter=0, 33-bit partial remainder=0, quotient reg = |dividend|.
- CALC, each edge: shift {rem,quo} left 1; trial = rem − |divisor|; if trial ≥ 0, rem=trial and quo[0]=1. counter+1. After iteration 31 (counter==31), go to FIX.
- FIX: apply q_neg/r_neg two's-complement negation. Load `result` (quotient or remainder by op[1]). Go to DONE.
- DONE: `done`=1 for exactly this cycle. Next state is IDLE, or back to CALC/DONE if a new `start` is accepted.
- `flush` in any state: next state IDLE, `done` not asserted, `result` unchanged, counter cleared.
- `rst_n` low mid-operation: immediately IDLE with all outputs at reset values; the operation is lost.

## Timing
- `ex_stall` = (state∈{CALC,FIX}) | (start & state∈{IDLE,DONE} & !flush).
  - Deasserted in DONE unless a new op is accepted, so EX advances in the cycle that consumes `result`.
- Normal latency: `start` accepted at edge E0; CALC on edges E1–E32; FIX at E33. `done`/`result` are valid in the cycle after E33.
  - `ex_stall` is high for 34 cycles: the start cycle through the FIX cycle.
- Fast-path latency: `done` is high in the cycle after E0; `ex_stall` is high only in the start cycle.
- `busy` is high from the cycle after E0 through the FIX cycle; it never rises on the fast path.
- Back-to-back: `start` in the DONE cycle is accepted with no idle bubble.
- `start`, `op` and operands are not required to stay stable after acceptance.

## Test plan
- DIVU 100/7 → `done` exactly 34 cycles after start cycle, `result`=14. REMU same operands → 2. `ex_stall` high 34 consecutive cycles.
- DIV −7 (0xFFFF_FFF9)/2 → 0xFFFF_FFFD (−3). REM → 0xFFFF_FFFF (−1). REM 7/−2 → 1.
- DIV 5/0 → 0xFFFF_FFFF; REM 5/0 → 5. Both: `done` the cycle after start, `busy` never high.
- DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000; REM same operands → 0. Both single-cycle.
- DIVU 0xFFFF_FFFF/1 → 0xFFFF_FFFF. `start` held high in the DONE cycle with a new op DIVU 9/3 → second `done` 34 cycles later with 3, no gap.
- `flush` at CALC iteration 10 → IDLE next cycle, no `done`, `result` keeps its previous value. `rst_n` pulsed low mid-CALC → all outputs 0 asynchronously.

Source files
------------

// File: rtl/rip_div_ctrl_if.sv
// rtl/rip_div_ctrl_if.sv - EX-stage request/response bundle for the RV32M divide sequencer
interface rip_div_ctrl_if #(parameter int XLEN = 32);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            ex_stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, dividend, divisor, flush,
    input  ex_stall, busy, done, result
  );

  modport slave (
    input  start, op, dividend, divisor, flush,
    output ex_stall, busy, done, result
  );
endinterface

// File: rtl/rip_div_ctrl.sv
// rtl/rip_div_ctrl.sv - DIV/DIVU/REM/REMU sequencer: 32-step restoring divide, single-cycle special cases
module rip_div_ctrl #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  rip_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [4:0]      cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            q_neg;
  logic            r_neg;
  logic            is_rem;
  logic [XLEN-1:0] result_q;
  logic            done_q;
  logic            busy_q;

  logic            op_signed;
  logic            accept;
  logic            div_zero;
  logic            sgn_ovf;
  logic            fast;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] fast_res;
  logic [XLEN+1:0] trial;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  always_comb begin
    op_signed = ~bus.op[0];
    accept    = bus.start & ~bus.flush & ((state == S_IDLE) | (state == S_DONE));
    div_zero  = (bus.divisor == '0);
    sgn_ovf   = op_signed
              & (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
              & (bus.divisor == '1);
    fast      = div_zero | sgn_ovf;
    a_mag     = (op_signed & bus.dividend[XLEN-1]) ? -bus.dividend : bus.dividend;
    b_mag     = (op_signed & bus.divisor[XLEN-1])  ? -bus.divisor  : bus.divisor;
    if (div_zero)
      fast_res = bus.op[1] ? bus.dividend : '1;
    else
      fast_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    // Sign bit of the 34-bit trial difference doubles as the restore decision.
    trial = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
    q_fix = q_neg ? -quo_q : quo_q;
    r_fix = r_neg ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept)
            state_nx = fast ? S_DONE : S_CALC;
          else
            state_nx = S_IDLE;
        end
        S_CALC:  if (cnt == 5'd31) state_nx = S_FIX;
        S_FIX:   state_nx = S_DONE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ex_stall = (state == S_CALC) | (state == S_FIX) | accept;
    bus.busy     = busy_q;
    bus.done     = done_q;
    bus.result   = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      is_rem   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_nx == S_CALC) | (state_nx == S_FIX);
      if (bus.flush) begin
        cnt <= '0;
      end else if (accept) begin
        is_rem <= bus.op[1];
        q_neg  <= op_signed & (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]) & ~div_zero;
        r_neg  <= op_signed & bus.dividend[XLEN-1];
        dvs_q  <= b_mag;
        quo_q  <= a_mag;
        rem_q  <= '0;
        cnt    <= '0;
        if (fast) begin
          result_q <= fast_res;
          done_q   <= 1'b1;
        end
      end else if (state == S_CALC) begin
        cnt <= cnt + 5'd1;
        if (!trial[XLEN+1]) begin
          rem_q <= trial[XLEN:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= {rem_q[XLEN-1:0], quo_q[XLEN-1]};
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
      end else if (state == S_FIX) begin
        result_q <= is_rem ? r_fix : q_fix;
        done_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rip_div_ctrl.sv
// tb/tb_rip_div_ctrl.sv - scoreboard bench for rip_div_ctrl against an arithmetic reference model
module tb_rip_div_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rip_div_ctrl_if bus ();

  rip_div_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] model_last = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb_;
    sa  = a;
    sb_ = b;
    if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb_;
      2'b01:   return a / b;
      2'b10:   return sa % sb_;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, result and cycle.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 32'(bus.done), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", bus.result, mon_e.res);
        chk("done latency", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic scramble_inputs();
    bus.op       = 2'($urandom);
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int   stalls;
    logic busy_seen;
    logic got;
    bit   f;
    f = is_fast(op, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.dividend = a; bus.divisor = b;
    sb.push_back('{ref_div(op, a, b), cyc + (f ? 1 : 34)});
    model_last = ref_div(op, a, b);
    #1;
    stalls    = bus.ex_stall ? 1 : 0;
    busy_seen = 1'b0;
    got       = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble_inputs();
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | bus.busy;
      if (bus.done) begin
        got = 1'b1;
        chk("ex_stall in done cycle", 32'(bus.ex_stall), 32'h0);
      end else if (bus.ex_stall) begin
        stalls++;
      end
    end
    chk("done seen", 32'(got), 32'h1);
    chk("ex_stall cycles", 32'(stalls), f ? 32'd1 : 32'd34);
    chk("busy seen", 32'(busy_seen), f ? 32'h0 : 32'h1);
  endtask

  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
  endtask

  task automatic back_to_back();
    logic got;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'hFFFF_FFFF; bus.divisor = 32'h1;
    sb.push_back('{ref_div(2'b01, 32'hFFFF_FFFF, 32'h1), cyc + 34});
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(got);
    chk("b2b first done", 32'(got), 32'h1);
    bus.start = 1'b1; bus.op = 2'b01; bus.dividend = 32'd9; bus.divisor = 32'd3;
    sb.push_back('{ref_div(2'b01, 32'd9, 32'd3), cyc + 34});
    model_last = ref_div(2'b01, 32'd9, 32'd3);
    #1;
    chk("b2b stall in done cycle", 32'(bus.ex_stall), 32'h1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    scramble_inputs();
    wait_done(got);
    chk("b2b second done", 32'(got), 32'h1);
  endtask

  task automatic flush_test();
    int seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.dividend = $urandom; bus.divisor = $urandom | 32'h1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy before flush", 32'(bus.busy), 32'h1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 32'(bus.busy), 32'h0);
    chk("flush ex_stall", 32'(bus.ex_stall), 32'h0);
    chk("flush done", 32'(bus.done), 32'h0);
    chk("flush result kept", bus.result, model_last);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("no done after flush", 32'(seen), 32'h0);
  endtask

  task automatic reset_test();
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.dividend = $urandom; bus.divisor = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset result", bus.result, 32'h0);
    chk("async reset done", 32'(bus.done), 32'h0);
    chk("async reset busy", 32'(bus.busy), 32'h0);
    chk("async reset ex_stall", 32'(bus.ex_stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 32'h0;
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    bus.start = 1'b0; bus.flush = 1'b0; bus.op = 2'b00;
    bus.dividend = 32'h0; bus.divisor = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset result", bus.result, 32'h0);
    chk("reset done", 32'(bus.done), 32'h0);
    chk("reset busy", 32'(bus.busy), 32'h0);
    chk("reset ex_stall", 32'(bus.ex_stall), 32'h0);
    rst_n = 1'b1;

    run_op(2'b01, 32'd100, 32'd7);
    run_op(2'b11, 32'd100, 32'd7);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op(2'b00, 32'd5, 32'd0);
    run_op(2'b10, 32'd5, 32'd0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    back_to_back();
    flush_test();

    for (int n = 0; n < 16; n++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb);
    end

    run_op(2'b01, 32'd100, 32'd7);
    reset_test();
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2);

    repeat (5) @(negedge clk);
    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
